// File: rtl/trace_recorder.sv
// Instruction-trace recorder: captures masked retire events into a small FIFO of records,
// with cycle/instruction/drop counters and a halt-triggered drain-to-done sequence.
module trace_recorder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            ev_mask,
  input  logic [DW-1:0]         pc,
  input  logic                  reg_we,
  input  logic [3:0]            reg_id,
  input  logic [DW-1:0]         reg_data,
  input  logic                  mem_re,
  input  logic                  mem_we,
  input  logic [DW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata,
  input  logic                  hlt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8+CW+4*DW-1:0]  out_rec,
  output logic [CW-1:0]         cycle_count,
  output logic [CW-1:0]         inst_count,
  output logic [CW-1:0]         drop_count,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned RecW = 8 + CW + 4 * DW;

  typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
  logic            ovf_q, ovf_d;
  logic [RecW-1:0] mem_q [DEPTH];

  logic [3:0]      kind;
  logic            empty, full, capture, push_req, push, pop, drop;
  logic [RecW-1:0] rec_in;

  always_comb begin
    kind     = {hlt, mem_we, mem_re, reg_we} & ev_mask;
    empty    = (wptr_q == rptr_q);
    // Extra pointer MSB distinguishes full from empty when the index bits match.
    full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    capture  = (state_q == StCapture);
    push_req = capture && (kind != 4'b0000);
    pop      = !empty && out_ready;
    push     = push_req && (!full || pop);
    drop     = push_req && !push;
    rec_in   = {kind, cycle_q, pc, reg_id, reg_data, mem_addr, mem_we ? mem_wdata : mem_rdata};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (en) state_d = StCapture;
      StCapture: begin
        // A halt record ends capture whether it was stored or dropped.
        if (push_req && kind[3]) state_d = StDrain;
        else if (!en)            state_d = StIdle;
      end
      StDrain:   if (empty) state_d = StDone;
      StDone:    state_d = StDone;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
    cycle_d = cycle_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    if (capture) begin
      cycle_d = cycle_q + CW'(1);
      if (hlt || reg_we || mem_we) inst_d = inst_q + CW'(1);
    end else if (state_q == StIdle && en) begin
      cycle_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cycle_q <= '0;
      inst_q  <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cycle_q <= cycle_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= rec_in;
  end

  assign out_valid   = !empty;
  assign out_rec     = mem_q[rptr_q[AW-1:0]];
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign drop_count  = drop_q;
  assign overflow    = ovf_q;
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_trace_recorder.sv
// Directed self-checking bench for trace_recorder: capture, backpressure/overflow, full
// push+pop, masking, halt/drain/done and mid-drain reset.
module tb_trace_recorder;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int CW    = 32;
  localparam int RW    = 8 + CW + 4 * DW;

  logic          clk = 1'b0;
  logic          rst, en, reg_we, mem_re, mem_we, hlt, out_ready;
  logic [3:0]    ev_mask, reg_id;
  logic [DW-1:0] pc, reg_data, mem_addr, mem_wdata, mem_rdata;
  logic          out_valid, overflow, done;
  logic [RW-1:0] out_rec;
  logic [CW-1:0] cycle_count, inst_count, drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trace_recorder #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .ev_mask(ev_mask), .pc(pc),
    .reg_we(reg_we), .reg_id(reg_id), .reg_data(reg_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
    .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
    .overflow(overflow), .done(done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_rec(input logic [3:0] k, input logic [CW-1:0] c,
                                           input logic [DW-1:0] p, input logic [3:0] rid,
                                           input logic [DW-1:0] rd, input logic [DW-1:0] ma,
                                           input logic [DW-1:0] md);
    return {k, c, p, rid, rd, ma, md};
  endfunction

  function automatic logic [CW-1:0] rec_cycle(input logic [RW-1:0] r);
    return r[4*DW+4 +: CW];
  endfunction

  function automatic logic [3:0] rec_kind(input logic [RW-1:0] r);
    return r[RW-4 +: 4];
  endfunction

  function automatic logic [DW-1:0] rec_rdata(input logic [RW-1:0] r);
    return r[2*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    en = 1'b0; ev_mask = 4'hF; pc = '0; reg_we = 1'b0; reg_id = '0; reg_data = '0;
    mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
    hlt = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_cycle", cycle_count, 0);
    check("rst_inst", inst_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ovf", overflow, 0);

    // Basic capture: reg write at capture cycle 2.
    out_ready = 1'b1; en = 1'b1;
    step(); step(); step();
    pc = 16'h0100; reg_we = 1'b1; reg_id = 4'd3; reg_data = 16'h00A5;
    step();
    reg_we = 1'b0;
    check("basic_valid", out_valid, 1);
    check("basic_rec", out_rec, mk_rec(4'b0001, 32'd2, 16'h0100, 4'd3, 16'h00A5, 16'h0, 16'h0));
    check("basic_inst", inst_count, 1);
    check("basic_cycle", cycle_count, 3);
    step();
    check("basic_popped", out_valid, 0);

    // Backpressure: 20 reg writes into a 16-deep FIFO.
    do_reset();
    en = 1'b1;
    step();
    reg_we = 1'b1; reg_id = 4'd5;
    for (int i = 0; i < 20; i++) begin
      reg_data = DW'(i); pc = DW'(i);
      step();
    end
    reg_we = 1'b0;
    check("bp_valid", out_valid, 1);
    check("bp_drop", drop_count, 4);
    check("bp_ovf", overflow, 1);
    check("bp_inst", inst_count, 20);
    check("bp_cycle", cycle_count, 20);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("bp_v%0d", k), out_valid, 1);
      check($sformatf("bp_c%0d", k), rec_cycle(out_rec), k);
      check($sformatf("bp_d%0d", k), rec_rdata(out_rec), k);
      step();
    end
    check("bp_empty", out_valid, 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    en = 1'b1;
    step();
    reg_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      reg_data = DW'(i);
      step();
    end
    reg_data = 16'hBEEF; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pp_nodrop", drop_count, 0);
    check("pp_head", rec_cycle(out_rec), 1);
    reg_data = 16'hCAFE;
    step();
    reg_we = 1'b0;
    check("pp_drop", drop_count, 1);
    check("pp_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("pp_c%0d", k), rec_cycle(out_rec), k + 1);
      step();
    end
    check("pp_last_empty", out_valid, 0);

    // Mask: store with only reg_we kind enabled.
    do_reset();
    ev_mask = 4'b0001; en = 1'b1; out_ready = 1'b1;
    step();
    mem_we = 1'b1; mem_addr = 16'h0040; mem_wdata = 16'h1234;
    step();
    mem_we = 1'b0;
    check("mask_norec", out_valid, 0);
    check("mask_inst", inst_count, 1);
    check("mask_drop", drop_count, 0);

    // Halt at cycle 7 with 3 records pending.
    do_reset();
    en = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      reg_we = (c >= 4 && c <= 6); hlt = (c == 7);
      reg_id = 4'(c); reg_data = DW'(16'h1000 + c); pc = DW'(c);
      step();
    end
    hlt = 1'b0; reg_we = 1'b1; reg_data = 16'hDEAD; mem_we = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("halt_v%0d", k), out_valid, 1);
      check($sformatf("halt_c%0d", k), rec_cycle(out_rec), 4 + k);
      check($sformatf("halt_k%0d", k), rec_kind(out_rec), (k == 3) ? 4'b1000 : 4'b0001);
      step();
    end
    check("halt_empty", out_valid, 0);
    step();
    check("halt_done", done, 1);
    step();
    check("halt_done_held", done, 1);
    check("halt_inst", inst_count, 4);
    check("halt_cycle", cycle_count, 8);
    check("halt_drop", drop_count, 0);
    reg_we = 1'b0; mem_we = 1'b0;

    // Reset in the middle of a drain.
    do_reset();
    en = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      reg_we = (c < 4); hlt = (c == 4); reg_data = DW'(c);
      step();
    end
    reg_we = 1'b0; hlt = 1'b0;
    check("mdr_pending", out_valid, 1);
    check("mdr_inst_pre", inst_count, 5);
    en = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mdr_valid", out_valid, 0);
    check("mdr_done", done, 0);
    check("mdr_cycle", cycle_count, 0);
    check("mdr_inst", inst_count, 0);
    check("mdr_drop", drop_count, 0);
    check("mdr_ovf", overflow, 0);
    step();
    check("mdr_idle_cycle", cycle_count, 0);
    check("mdr_idle_valid", out_valid, 0);
    check("mdr_idle_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
